// File: rtl/decode_wb_param.sv
// decode_wb_param
//   Parametrised Y86-64 decode / write-back stage: register file, operand
//   source/destination selection, five-way forwarding (optional), load/use
//   or RAW hazard detection, and the D->E pipeline register with bubbles.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   D_*                  decoded instruction fields from the D register
//   e_/M_/m_/W_ dst,val  later-stage destinations and values (forwarding,
//                        write-back)
//   E_bubble             load a nop into the E register
//   E_*                  registered D->E pipeline outputs
//   d_srcA/B, d_valA/B   combinational selected sources and operand values
//   d_hazard             combinational stall request (advisory)
//   reg_flat             register file contents, reg i at [i*XLEN +: XLEN]
module decode_wb_param #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     NREG      = 15,
  parameter int unsigned     RID_W     = 4,
  parameter bit              FWD_EN    = 1'b1,
  parameter int unsigned     RSP_ID    = 4,
  parameter logic [XLEN-1:0] RSP_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           D_stat,
  input  logic [3:0]           D_icode,
  input  logic [3:0]           D_ifun,
  input  logic [RID_W-1:0]     D_rA,
  input  logic [RID_W-1:0]     D_rB,
  input  logic [XLEN-1:0]      D_valC,
  input  logic [XLEN-1:0]      D_valP,
  input  logic [RID_W-1:0]     e_dstE,
  input  logic [XLEN-1:0]      e_valE,
  input  logic [RID_W-1:0]     M_dstE,
  input  logic [RID_W-1:0]     M_dstM,
  input  logic [XLEN-1:0]      M_valE,
  input  logic [XLEN-1:0]      m_valM,
  input  logic [RID_W-1:0]     W_dstE,
  input  logic [RID_W-1:0]     W_dstM,
  input  logic [XLEN-1:0]      W_valE,
  input  logic [XLEN-1:0]      W_valM,
  input  logic                 E_bubble,
  output logic [3:0]           E_stat,
  output logic [3:0]           E_icode,
  output logic [3:0]           E_ifun,
  output logic [XLEN-1:0]      E_valC,
  output logic [XLEN-1:0]      E_valA,
  output logic [XLEN-1:0]      E_valB,
  output logic [RID_W-1:0]     E_dstE,
  output logic [RID_W-1:0]     E_dstM,
  output logic [RID_W-1:0]     E_srcA,
  output logic [RID_W-1:0]     E_srcB,
  output logic [RID_W-1:0]     d_srcA,
  output logic [RID_W-1:0]     d_srcB,
  output logic [XLEN-1:0]      d_valA,
  output logic [XLEN-1:0]      d_valB,
  output logic                 d_hazard,
  output logic [NREG*XLEN-1:0] reg_flat
);

  localparam logic [RID_W-1:0] RNONE = '1;
  localparam logic [RID_W-1:0] RSP   = RID_W'(RSP_ID);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;

  logic [NREG*XLEN-1:0] r_regs;
  logic [RID_W-1:0]     w_srcA, w_srcB, w_dstE, w_dstM;
  logic [XLEN-1:0]      w_valA, w_valB;
  logic                 w_hazard;

  function automatic logic id_ok(input logic [RID_W-1:0] id);
    return (id != RNONE) && (32'(id) < NREG);
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [RID_W-1:0] id);
    logic [XLEN-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++)
      if (32'(id) == i) v = r_regs[i*XLEN +: XLEN];
    return v;
  endfunction

  // Nearest pipeline stage wins; invalid or absent sources always read 0.
  function automatic logic [XLEN-1:0] operand(input logic [RID_W-1:0] src);
    if (!id_ok(src)) return '0;
    if (FWD_EN) begin
      if (src == e_dstE) return e_valE;
      if (src == M_dstM) return m_valM;
      if (src == M_dstE) return M_valE;
      if (src == W_dstM) return W_valM;
      if (src == W_dstE) return W_valE;
    end
    return rf_read(src);
  endfunction

  function automatic logic raw_hit(input logic [RID_W-1:0] src);
    return (src != RNONE) &&
           (src == e_dstE || src == M_dstE || src == M_dstM ||
            src == W_dstE || src == W_dstM);
  endfunction

  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: w_srcA = D_rA;
      I_RET, I_POPQ:                      w_srcA = RSP;
      default:                            w_srcA = RNONE;
    endcase
    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          w_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_srcB = RSP;
      default:                            w_srcB = RNONE;
    endcase
    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          w_dstE = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_dstE = RSP;
      default:                            w_dstE = RNONE;
    endcase
    case (D_icode)
      I_MRMOVQ, I_POPQ:                   w_dstM = D_rA;
      default:                            w_dstM = RNONE;
    endcase
  end

  always_comb begin
    w_valA = operand(w_srcA);
    w_valB = operand(w_srcB);
    if (D_icode == I_JXX || D_icode == I_CALL) w_valA = D_valP;
    if (FWD_EN)
      w_hazard = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != RNONE) &&
                 (E_dstM == w_srcA || E_dstM == w_srcB);
    else
      w_hazard = raw_hit(w_srcA) || raw_hit(w_srcB);
  end

  // valM is applied after valE so a popq %rsp leaves the loaded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_regs[RSP_ID*XLEN +: XLEN] <= RSP_RESET;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (id_ok(W_dstM) && 32'(W_dstM) == i)
          r_regs[i*XLEN +: XLEN] <= W_valM;
        else if (id_ok(W_dstE) && 32'(W_dstE) == i)
          r_regs[i*XLEN +: XLEN] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= w_valA;
      E_valB  <= w_valB;
      E_dstE  <= w_dstE;
      E_dstM  <= w_dstM;
      E_srcA  <= w_srcA;
      E_srcB  <= w_srcB;
    end
  end

  assign d_srcA   = w_srcA;
  assign d_srcB   = w_srcB;
  assign d_valA   = w_valA;
  assign d_valB   = w_valB;
  assign d_hazard = w_hazard;
  assign reg_flat = r_regs;

endmodule

// File: tb/tb_decode_wb_param.sv
// tb_decode_wb_param
//   Drives two decode_wb_param instances from shared stimulus: a forwarding
//   64-bit/15-register one and a non-forwarding 32-bit/8-register one.
//   A behavioural model (register arrays, priority list of producers)
//   predicts every output each cycle; literal checks pin the model.
module tb_decode_wb_param;

  typedef struct {
    logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB;
  } ereg_t;

  typedef struct {
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;
    logic        haz;
  } dec_t;

  logic        clk, reset, E_bubble;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] D_valC, D_valP, e_valE, M_valE, m_valM, W_valE, W_valM;

  logic [3:0]  f_E_stat, f_E_icode, f_E_ifun, f_E_dstE, f_E_dstM, f_E_srcA, f_E_srcB;
  logic [3:0]  f_d_srcA, f_d_srcB;
  logic [63:0] f_E_valC, f_E_valA, f_E_valB, f_d_valA, f_d_valB;
  logic        f_d_hazard;
  logic [15*64-1:0] f_reg_flat;

  logic [3:0]  n_E_stat, n_E_icode, n_E_ifun, n_E_dstE, n_E_dstM, n_E_srcA, n_E_srcB;
  logic [3:0]  n_d_srcA, n_d_srcB;
  logic [31:0] n_E_valC, n_E_valA, n_E_valB, n_d_valA, n_d_valB;
  logic        n_d_hazard;
  logic [8*32-1:0] n_reg_flat;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mreg [2][16];
  ereg_t       mE [2];

  decode_wb_param #(
    .XLEN(64), .NREG(15), .RID_W(4), .FWD_EN(1'b1), .RSP_ID(4), .RSP_RESET(64'h100)
  ) dut_fwd (
    .clk(clk), .reset(reset), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .E_bubble(E_bubble),
    .E_stat(f_E_stat), .E_icode(f_E_icode), .E_ifun(f_E_ifun),
    .E_valC(f_E_valC), .E_valA(f_E_valA), .E_valB(f_E_valB),
    .E_dstE(f_E_dstE), .E_dstM(f_E_dstM), .E_srcA(f_E_srcA), .E_srcB(f_E_srcB),
    .d_srcA(f_d_srcA), .d_srcB(f_d_srcB), .d_valA(f_d_valA), .d_valB(f_d_valB),
    .d_hazard(f_d_hazard), .reg_flat(f_reg_flat)
  );

  decode_wb_param #(
    .XLEN(32), .NREG(8), .RID_W(4), .FWD_EN(1'b0), .RSP_ID(4), .RSP_RESET(32'h200)
  ) dut_nofwd (
    .clk(clk), .reset(reset), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC[31:0]), .D_valP(D_valP[31:0]),
    .e_dstE(e_dstE), .e_valE(e_valE[31:0]), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE[31:0]), .m_valM(m_valM[31:0]), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE[31:0]), .W_valM(W_valM[31:0]), .E_bubble(E_bubble),
    .E_stat(n_E_stat), .E_icode(n_E_icode), .E_ifun(n_E_ifun),
    .E_valC(n_E_valC), .E_valA(n_E_valA), .E_valB(n_E_valB),
    .E_dstE(n_E_dstE), .E_dstM(n_E_dstM), .E_srcA(n_E_srcA), .E_srcB(n_E_srcB),
    .d_srcA(n_d_srcA), .d_srcB(n_d_srcB), .d_valA(n_d_valA), .d_valB(n_d_valB),
    .d_hazard(n_d_hazard), .reg_flat(n_reg_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nreg_of(input int c);
    return (c == 0) ? 15 : 8;
  endfunction

  function automatic logic [63:0] mask_of(input int c);
    return (c == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic ereg_t bubble_e();
    ereg_t b;
    b.stat = 4'h1; b.icode = 4'h1; b.ifun = 4'h0;
    b.dstE = 4'hF; b.dstM = 4'hF; b.srcA = 4'hF; b.srcB = 4'hF;
    b.valC = '0;   b.valA = '0;   b.valB = '0;
    return b;
  endfunction

  // Operand value from the producers, nearest stage first, then the regfile.
  function automatic logic [63:0] model_read(input int c, input logic [3:0] s);
    logic [3:0]  ids [5];
    logic [63:0] vals [5];
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == 4'hF || int'(s) >= nreg_of(c)) return '0;
    if (c == 0)
      for (int k = 0; k < 5; k++)
        if (ids[k] == s) return vals[k];
    return mreg[c][s];
  endfunction

  function automatic dec_t model_dec(input int c);
    dec_t d;
    logic [3:0] ic;
    logic [3:0] dsts [5];
    ic = D_icode;
    dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    d.srcA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
             (ic inside {4'h9, 4'hB}) ? 4'd4 : 4'hF;
    d.srcB = (ic inside {4'h4, 4'h5, 4'h6}) ? D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'hF;
    d.dstE = (ic inside {4'h2, 4'h3, 4'h6}) ? D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'hF;
    d.dstM = (ic inside {4'h5, 4'hB}) ? D_rA : 4'hF;
    d.valA = (ic inside {4'h7, 4'h8}) ? (D_valP & mask_of(c))
                                      : (model_read(c, d.srcA) & mask_of(c));
    d.valB = model_read(c, d.srcB) & mask_of(c);
    d.haz = 1'b0;
    if (c == 0) begin
      d.haz = (mE[0].icode inside {4'h5, 4'hB}) && mE[0].dstM != 4'hF &&
              (mE[0].dstM == d.srcA || mE[0].dstM == d.srcB);
    end else begin
      for (int k = 0; k < 5; k++)
        if ((d.srcA != 4'hF && d.srcA == dsts[k]) || (d.srcB != 4'hF && d.srcB == dsts[k]))
          d.haz = 1'b1;
    end
    return d;
  endfunction

  function automatic ereg_t obs_e(input int c);
    ereg_t o;
    if (c == 0) begin
      o.stat = f_E_stat; o.icode = f_E_icode; o.ifun = f_E_ifun;
      o.dstE = f_E_dstE; o.dstM = f_E_dstM; o.srcA = f_E_srcA; o.srcB = f_E_srcB;
      o.valC = f_E_valC; o.valA = f_E_valA; o.valB = f_E_valB;
    end else begin
      o.stat = n_E_stat; o.icode = n_E_icode; o.ifun = n_E_ifun;
      o.dstE = n_E_dstE; o.dstM = n_E_dstM; o.srcA = n_E_srcA; o.srcB = n_E_srcB;
      o.valC = 64'(n_E_valC); o.valA = 64'(n_E_valA); o.valB = 64'(n_E_valB);
    end
    return o;
  endfunction

  function automatic logic [63:0] obs_reg(input int c, input int i);
    return (c == 0) ? f_reg_flat[i*64 +: 64] : 64'(n_reg_flat[i*32 +: 32]);
  endfunction

  task automatic chk(input string tag, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic compare_model();
    dec_t  d;
    ereg_t o;
    string tag;
    for (int c = 0; c < 2; c++) begin
      tag = (c == 0) ? "fwd" : "nofwd";
      d = model_dec(c);
      chk(tag, "d_srcA", 64'(c == 0 ? f_d_srcA : n_d_srcA), 64'(d.srcA));
      chk(tag, "d_srcB", 64'(c == 0 ? f_d_srcB : n_d_srcB), 64'(d.srcB));
      chk(tag, "d_valA", c == 0 ? f_d_valA : 64'(n_d_valA), d.valA);
      chk(tag, "d_valB", c == 0 ? f_d_valB : 64'(n_d_valB), d.valB);
      chk(tag, "d_hazard", 64'(c == 0 ? f_d_hazard : n_d_hazard), 64'(d.haz));
      o = obs_e(c);
      chk(tag, "E_stat",  64'(o.stat),  64'(mE[c].stat));
      chk(tag, "E_icode", 64'(o.icode), 64'(mE[c].icode));
      chk(tag, "E_ifun",  64'(o.ifun),  64'(mE[c].ifun));
      chk(tag, "E_dstE",  64'(o.dstE),  64'(mE[c].dstE));
      chk(tag, "E_dstM",  64'(o.dstM),  64'(mE[c].dstM));
      chk(tag, "E_srcA",  64'(o.srcA),  64'(mE[c].srcA));
      chk(tag, "E_srcB",  64'(o.srcB),  64'(mE[c].srcB));
      chk(tag, "E_valC",  o.valC, mE[c].valC);
      chk(tag, "E_valA",  o.valA, mE[c].valA);
      chk(tag, "E_valB",  o.valB, mE[c].valB);
      for (int i = 0; i < nreg_of(c); i++)
        if (obs_reg(c, i) !== mreg[c][i])
          chk(tag, $sformatf("reg%0d", i), obs_reg(c, i), mreg[c][i]);
        else
          n_checks++;
    end
  endtask

  task automatic eval();
    #1;
    compare_model();
  endtask

  task automatic tick();
    dec_t        d;
    ereg_t       ne [2];
    logic [63:0] nr [2][16];
    for (int c = 0; c < 2; c++) begin
      d = model_dec(c);
      for (int i = 0; i < 16; i++)
        nr[c][i] = reset ? ((i == 4) ? (c == 0 ? 64'h100 : 64'h200) : 64'h0) : mreg[c][i];
      if (!reset) begin
        if (W_dstE != 4'hF && int'(W_dstE) < nreg_of(c)) nr[c][W_dstE] = W_valE & mask_of(c);
        if (W_dstM != 4'hF && int'(W_dstM) < nreg_of(c)) nr[c][W_dstM] = W_valM & mask_of(c);
      end
      if (reset || E_bubble) begin
        ne[c] = bubble_e();
      end else begin
        ne[c].stat = D_stat; ne[c].icode = D_icode; ne[c].ifun = D_ifun;
        ne[c].valC = D_valC & mask_of(c); ne[c].valA = d.valA; ne[c].valB = d.valB;
        ne[c].dstE = d.dstE; ne[c].dstM = d.dstM; ne[c].srcA = d.srcA; ne[c].srcB = d.srcB;
      end
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      mE[c] = ne[c];
      for (int i = 0; i < 16; i++) mreg[c][i] = nr[c][i];
    end
    #1;
  endtask

  task automatic idle_fwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    D_icode = ic; D_rA = ra; D_rB = rb;
  endtask

  function automatic logic [3:0] rnd_id();
    int v;
    v = $urandom_range(0, 19);
    if (v < 10) return 4'(v % 8);
    if (v < 14) return 4'hF;
    return 4'($urandom_range(8, 14));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    for (int c = 0; c < 2; c++) begin
      mE[c] = bubble_e();
      for (int i = 0; i < 16; i++) mreg[c][i] = '0;
    end
    reset = 1'b1; E_bubble = 1'b0;
    D_stat = 4'h1; D_ifun = 4'h0; D_valC = '0; D_valP = '0;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    idle_fwd();
    set_d(4'h6, 4'hF, 4'hF);
    tick();
    reset = 1'b0;
    eval();
    chk("lit", "rst reg4",    obs_reg(0, 4), 64'h100);
    chk("lit", "rst reg0",    obs_reg(0, 0), 64'h0);
    chk("lit", "rst nreg4",   obs_reg(1, 4), 64'h200);
    chk("lit", "rst E_icode", 64'(f_E_icode), 64'h1);
    chk("lit", "rst E_dstE",  64'(f_E_dstE),  64'hF);
    chk("lit", "rst E_stat",  64'(f_E_stat),  64'h1);

    W_dstE = 4'd3; W_valE = 64'h55;
    set_d(4'h6, 4'd3, 4'd3);
    eval();
    chk("lit", "wfwd valA", f_d_valA, 64'h55);
    chk("lit", "wfwd valB", f_d_valB, 64'h55);
    tick();
    idle_fwd();
    eval();
    chk("lit", "wfwd E_valA", f_E_valA, 64'h55);
    chk("lit", "wb reg3",     obs_reg(0, 3), 64'h55);

    e_dstE = 4'd2; e_valE = 64'h11;
    M_dstM = 4'd2; m_valM = 64'h22;
    W_dstE = 4'd2; W_valE = 64'h33;
    set_d(4'h2, 4'd2, 4'hF);
    eval();
    chk("lit", "prio e",     f_d_valA, 64'h11);
    chk("lit", "nofwd haz",  64'(n_d_hazard), 64'h1);
    chk("lit", "nofwd old",  64'(n_d_valA), 64'h0);
    e_dstE = 4'hF;
    eval();
    chk("lit", "prio M",     f_d_valA, 64'h22);
    M_dstM = 4'hF;
    eval();
    chk("lit", "prio W",     f_d_valA, 64'h33);
    tick();
    idle_fwd();
    M_dstE = 4'd2; M_valE = 64'h77;
    eval();
    chk("lit", "nofwd stale", 64'(n_d_valA), 64'h33);
    chk("lit", "nofwd Mhaz",  64'(n_d_hazard), 64'h1);
    chk("lit", "fwd MvalE",   f_d_valA, 64'h77);
    idle_fwd();

    W_dstE = 4'd4; W_valE = 64'h80; W_dstM = 4'd4; W_valM = 64'h99;
    set_d(4'h1, 4'hF, 4'hF);
    tick();
    idle_fwd();
    eval();
    chk("lit", "pop reg4",  obs_reg(0, 4), 64'h99);
    chk("lit", "pop nreg4", obs_reg(1, 4), 64'h99);

    set_d(4'h5, 4'd1, 4'd6);
    tick();
    set_d(4'h6, 4'd1, 4'd2);
    eval();
    chk("lit", "lu E_icode", 64'(f_E_icode), 64'h5);
    chk("lit", "lu hazard",  64'(f_d_hazard), 64'h1);
    E_bubble = 1'b1;
    tick();
    E_bubble = 1'b0;
    eval();
    chk("lit", "bub E_icode", 64'(f_E_icode), 64'h1);
    chk("lit", "bub E_dstE",  64'(f_E_dstE),  64'hF);
    chk("lit", "bub E_dstM",  64'(f_E_dstM),  64'hF);
    chk("lit", "bub hazard",  64'(f_d_hazard), 64'h0);

    set_d(4'h8, 4'hF, 4'hF);
    D_valP = 64'h40;
    eval();
    chk("lit", "call nvalA", 64'(n_d_valA), 64'h40);
    chk("lit", "call nhaz",  64'(n_d_hazard), 64'h0);
    chk("lit", "call fvalA", f_d_valA, 64'h40);

    W_dstE = 4'd5; W_valE = 64'hAB;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_fwd();
    eval();
    chk("lit", "rstpri reg5",  obs_reg(0, 5), 64'h0);
    chk("lit", "rstpri nreg5", obs_reg(1, 5), 64'h0);
    chk("lit", "rstpri reg4",  obs_reg(0, 4), 64'h100);

    for (int n = 0; n < 600; n++) begin
      D_stat  = 4'($urandom_range(0, 15));
      D_icode = 4'($urandom_range(0, 15));
      D_ifun  = 4'($urandom_range(0, 15));
      D_rA = rnd_id(); D_rB = rnd_id();
      D_valC = rnd64(); D_valP = rnd64();
      e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = rnd64(); M_valE = rnd64(); m_valM = rnd64();
      W_valE = rnd64(); W_valM = rnd64();
      E_bubble = ($urandom_range(0, 5) == 0);
      reset    = ($urandom_range(0, 79) == 0);
      eval();
      tick();
    end
    reset = 1'b0;
    E_bubble = 1'b0;
    eval();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
